// File: rtl/req_encoder_hs_if.sv
// Request-encoder bus: request lines, flush and the encoded-index valid/ready stream.
// A code transfers on a rising edge where out_valid && out_ready. Once out_valid
// rises, out_code and out_valid hold until that transfer or a flush/reset.
interface req_encoder_hs_if #(
  parameter int N_REQ  = 8,
  parameter int CODE_W = 3
);
  logic [N_REQ-1:0]  req;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic [N_REQ-1:0]  pending;
  logic              overflow;

  modport master (
    output req, flush, out_ready,
    input  out_valid, out_code, pending, overflow
  );

  modport slave (
    input  req, flush, out_ready,
    output out_valid, out_code, pending, overflow
  );
endinterface

// File: rtl/req_encoder_hs.sv
// Registered N:log2(N) request encoder. It captures request strobes into a pending
// set and issues their indices one per transfer, by fixed priority or round-robin.
module req_encoder_hs #(
  parameter int N_REQ  = 8,
  parameter int CODE_W = 3,
  parameter int RR     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  req_encoder_hs_if.slave   bus,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d, issue_mask;
  logic [CODE_W-1:0] code_q, code_d, ptr_q, ptr_d;
  logic [CODE_W-1:0] start, idx, sel;
  logic              found, load, ovf_q, ovf_d;

  // The search scans only the pending register. Raw req reaches pending first,
  // which costs one edge of latency.
  always_comb begin
    start = (RR != 0) ? ptr_q : '0;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + CODE_W'(i);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ptr_d      = ptr_q;
    load       = 1'b0;
    issue_mask = '0;
    case (state_q)
      IDLE: load = found;
      HOLD: begin
        if (bus.out_ready) begin
          if (found) load = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d    = HOLD;
      code_d     = sel;
      ptr_d      = sel + CODE_W'(1);
      issue_mask = N_REQ'(1) << sel;
    end
    // A request on the bit being issued this edge counts as a new event, not an overflow.
    pending_d = (pending_q & ~issue_mask) | bus.req;
    ovf_d     = ovf_q | (|(bus.req & pending_q & ~issue_mask));
    if (bus.flush) begin
      state_d   = IDLE;
      code_d    = '0;
      ptr_d     = ptr_q;
      pending_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_code  = code_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state     = state_q;

endmodule
